// File: rtl/alu_lanes_pipe_if.sv
// alu_lanes_pipe_if: valid/ready operand and result bundle for the SIMD ALU lanes
interface alu_lanes_pipe_if #(
  parameter int N = 8,
  parameter int LANES = 6,
  parameter int IW = $clog2(LANES)
);
  logic in_valid;
  logic in_ready;
  logic [LANES-1:0][N-1:0] SrcAE;
  logic [LANES-1:0][N-1:0] SrcBE;
  logic [IW-1:0] SrcBiE;
  logic [N-1:0] Imm;
  logic [1:0] VSIFlag;
  logic [2:0] ALUControl;
  logic [LANES-1:0] LaneMask;
  logic out_valid;
  logic out_ready;
  logic [LANES-1:0][N-1:0] ALUResult;
  logic [LANES-1:0][1:0] ALUFlags;
  modport master (
    output in_valid, SrcAE, SrcBE, SrcBiE, Imm, VSIFlag, ALUControl, LaneMask, out_ready,
    input in_ready, out_valid, ALUResult, ALUFlags
  );
  modport slave (
    input in_valid, SrcAE, SrcBE, SrcBiE, Imm, VSIFlag, ALUControl, LaneMask, out_ready,
    output in_ready, out_valid, ALUResult, ALUFlags
  );
endinterface

// File: rtl/alu_lanes_pipe.sv
// alu_lanes_pipe: LANES-wide SIMD ALU, 2-stage valid/ready pipeline; define VALU_SAT_EN for saturating signed ADD/SUB
module alu_lanes_pipe #(
  parameter int N = 8,
  parameter int LANES = 6,
  parameter int IW = $clog2(LANES)
) (
  input logic clk,
  input logic rst_n,
  alu_lanes_pipe_if.slave bus
);
  localparam int IWS = $clog2(N);
  logic adv1, adv2;
  logic s1_v, s2_v;
  logic [LANES-1:0][N-1:0] s1_a, s1_b, b_sel, res_c, s2_res;
  logic [LANES-1:0][1:0] flg_c, s2_flg;
  logic [2:0] s1_op;
  logic [LANES-1:0] s1_mask;
  logic [IW-1:0] bi;
  logic [N-1:0] b_scl;
  assign adv2 = !s2_v || bus.out_ready;
  assign adv1 = !s1_v || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = s2_v;
  assign bus.ALUResult = s2_res;
  assign bus.ALUFlags = s2_flg;
  assign bi = bus.SrcBiE;
  assign b_scl = (int'(bi) < LANES) ? bus.SrcBE[bi] : '0;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [N-1:0] a, b, sum, dif, r;
    assign b_sel[i] = bus.VSIFlag == 2'b01 ? b_scl : bus.VSIFlag == 2'b10 ? bus.Imm : bus.SrcBE[i];
    assign a = s1_a[i];
    assign b = s1_b[i];
`ifdef VALU_SAT_EN
    logic [N-1:0] add_w, sub_w, lim;
    assign add_w = a + b;
    assign sub_w = a - b;
    assign lim = {a[N-1], {(N-1){!a[N-1]}}};
    assign sum = (a[N-1] == b[N-1] && add_w[N-1] != a[N-1]) ? lim : add_w;
    assign dif = (a[N-1] != b[N-1] && sub_w[N-1] != a[N-1]) ? lim : sub_w;
`else
    assign sum = a + b;
    assign dif = a - b;
`endif
    // lane operation selected by the registered ALUControl
    always_comb begin
      case (s1_op)
        3'd0: r = sum;
        3'd1: r = dif;
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = a << b[IWS-1:0];
        3'd6: r = a >> b[IWS-1:0];
        default: r = a * b;
      endcase
    end
    assign res_c[i] = s1_mask[i] ? r : a;
    assign flg_c[i] = s1_mask[i] ? {r[N-1], r == '0} : 2'b00;
  end
  // S1 loads on accept, S2 loads whenever an occupied S1 can advance into it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_op <= '0;
      s1_mask <= '0;
      s2_res <= '0;
      s2_flg <= '0;
    end else begin
      if (adv1) s1_v <= bus.in_valid;
      if (adv1 && bus.in_valid) begin
        s1_a <= bus.SrcAE;
        s1_b <= b_sel;
        s1_op <= bus.ALUControl;
        s1_mask <= bus.LaneMask;
      end
      if (adv2) s2_v <= s1_v;
      if (adv2 && s1_v) begin
        s2_res <= res_c;
        s2_flg <= flg_c;
      end
    end
  end
endmodule
